// File: rtl/seq_pkg.sv
// Shared definitions for the sequence blocks (pattern transmitter and
// sequence detectors): default sizing and the common 3-state FSM encoding.
package seq_pkg;

    localparam int SEQ_WIDTH = 8;   // default maximum pattern length in bits
    localparam int SEQ_LEN_W = 4;   // default width of length/repeat fields

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter.
// Captures a pattern on start and shifts it out MSB-first. The pattern is
// len bits long and is sent rep+1 times back to back, with no gap between
// repetitions. A one-cycle done pulse follows the last bit. abort cancels
// the transfer and suppresses done.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset
//   start  - transfer request, only looked at in IDLE
//   data   - pattern, sent from data[WIDTH-1] downward
//   len    - bits per repetition; 0 or >WIDTH means WIDTH
//   rep    - number of extra repetitions
//   abort  - synchronous cancel (also blocks start in IDLE)
//   out    - serial bit, 0 whenever valid=0
//   valid  - out holds a pattern bit
//   busy   - in SHIFT or DONE
//   done   - one-cycle pulse after the final bit
module serial_pattern_tx
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int LEN_W = SEQ_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    input  logic [LEN_W-1:0] rep,
    input  logic             abort,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    // Wide enough to hold WIDTH itself (the stored effective length).
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t state_q, state_d;
    state_t state;                    // hierarchical monitor name
    assign state = state_q;

    logic [WIDTH-1:0] shift_q, shift_d;   // working shift register
    logic [WIDTH-1:0] pat_q,   pat_d;     // captured pattern for reloads
    logic [CNT_W-1:0] len_q,   len_d;     // captured effective length
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d; // bits left in this repetition, minus one
    logic [LEN_W-1:0] rep_q,   rep_d;     // repetitions still to go

    logic [CNT_W-1:0] len_eff;
    logic             accept;
    logic             last_bit;
    logic             last_rep;

    always_comb begin
        if (len == '0 || int'(len) > WIDTH) len_eff = CNT_W'(WIDTH);
        else                                len_eff = CNT_W'(len);
    end

    // abort has priority over start in IDLE
    assign accept   = start && !abort;
    assign last_bit = (bit_cnt_q == '0);
    assign last_rep = (rep_q == '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT: begin
                if (abort)                    state_d = IDLE;
                else if (last_bit && last_rep) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        out   = 1'b0;
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            SHIFT: begin
                out   = shift_q[WIDTH-1];
                valid = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_comb begin
        shift_d   = shift_q;
        pat_d     = pat_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        rep_d     = rep_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d   = data;
                    pat_d     = data;
                    len_d     = len_eff;
                    bit_cnt_d = len_eff - CNT_W'(1);
                    rep_d     = rep;
                end
            end
            SHIFT: begin
                if (!abort) begin
                    if (!last_bit) begin
                        shift_d   = shift_q << 1;
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end else if (!last_rep) begin
                        // Reload so the next repetition starts on the very next cycle.
                        shift_d   = pat_q;
                        bit_cnt_d = len_q - CNT_W'(1);
                        rep_d     = rep_q - LEN_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            rep_q     <= '0;
        end else begin
            shift_q   <= shift_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            rep_q     <= rep_d;
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: reset, basic transfer, repetition,
// length clamping, start-while-busy, abort, abort-vs-start, async reset.
module tb_serial_pattern_tx;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data = '0;
    logic [3:0] len = '0;
    logic [3:0] rep = '0;
    logic       abort = 1'b0;
    logic       out, valid, busy, done;

    int checks = 0;
    int errors = 0;

    serial_pattern_tx dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .len(len),
        .rep(rep), .abort(abort), .out(out), .valid(valid), .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Drive a one-cycle start pulse; returns at the negedge of the first SHIFT cycle.
    task automatic start_xfer(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
        @(negedge clk);
        data = d; len = l; rep = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Record the serial stream from the current negedge until done or idle.
    task automatic collect(input int max_cyc, output logic [63:0] bits, output int nv,
                           output int nd, output int bad, output bit timed_out);
        bit fin;
        bits = '0; nv = 0; nd = 0; bad = 0; fin = 1'b0;
        for (int c = 0; c < max_cyc && !fin; c++) begin
            if (valid) begin
                bits = {bits[62:0], out};
                nv++;
            end else begin
                if (out !== 1'b0) bad++;
                if (busy && !done) bad++;   // gap inside a transfer
            end
            if (done) nd++;
            if (done || !busy) fin = 1'b1;
            @(negedge clk);
        end
        timed_out = !fin;
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({out, valid, busy, done} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs: got %b exp 0000", {out, valid, busy, done});
        end
        checks++; if (dut.state !== IDLE) begin
            errors++; $display("FAIL reset_state: got %0d exp 0", dut.state);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle_busy: got %b exp 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [63:0] b; int nv, nd, bad; bit to;
        start_xfer(8'b1011_0000, 4'd4, 4'd0);
        checks++; if (valid !== 1'b1 || out !== 1'b1) begin
            errors++; $display("FAIL basic_latency: got valid=%b out=%b exp 1 1", valid, out);
        end
        collect(20, b, nv, nd, bad, to);
        checks++; if (to || nv != 4 || b[3:0] !== 4'b1011) begin
            errors++; $display("FAIL basic_bits: got n=%0d bits=%b exp n=4 bits=1011", nv, b[3:0]);
        end
        checks++; if (nd != 1 || bad != 0) begin
            errors++; $display("FAIL basic_done: got done=%0d bad=%0d exp 1 0", nd, bad);
        end
        checks++; if (dut.state !== IDLE || busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got state=%0d busy=%b exp 0 0", dut.state, busy);
        end
    endtask

    task automatic test_repeat();
        logic [63:0] b; int nv, nd, bad, hits; bit to;
        start_xfer(8'b1011_0000, 4'd4, 4'd2);
        collect(40, b, nv, nd, bad, to);
        checks++; if (to || nv != 12 || b[11:0] !== 12'b1011_1011_1011) begin
            errors++; $display("FAIL repeat_bits: got n=%0d bits=%b exp n=12 bits=101110111011", nv, b[11:0]);
        end
        checks++; if (nd != 1 || bad != 0) begin
            errors++; $display("FAIL repeat_contig: got done=%0d bad=%0d exp 1 0", nd, bad);
        end
        hits = 0;
        for (int i = 0; i <= 8; i++) if (b[11-i -: 4] == 4'b1011) hits++;
        checks++; if (hits != 3) begin
            errors++; $display("FAIL repeat_detect: got %0d exp 3", hits);
        end
    endtask

    task automatic test_len_clamp();
        logic [63:0] b; int nv, nd, bad; bit to;
        logic [3:0] lens [2] = '{4'd0, 4'd12};
        foreach (lens[k]) begin
            start_xfer(8'hA5, lens[k], 4'd0);
            collect(30, b, nv, nd, bad, to);
            checks++; if (to || nv != 8 || b[7:0] !== 8'hA5 || nd != 1) begin
                errors++; $display("FAIL clamp_len%0d: got n=%0d bits=%h done=%0d exp n=8 bits=a5 done=1",
                                   lens[k], nv, b[7:0], nd);
            end
        end
    endtask

    // start held high through SHIFT and DONE while inputs change underneath
    task automatic test_start_busy();
        logic [63:0] b; int nv, nd, bad; bit to;
        start_xfer(8'b1011_0000, 4'd4, 4'd0);
        start = 1'b1; data = 8'hFF; len = 4'd2; rep = 4'd3;
        collect(20, b, nv, nd, bad, to);
        start = 1'b0;
        checks++; if (to || nv != 4 || b[3:0] !== 4'b1011 || nd != 1) begin
            errors++; $display("FAIL busy_start: got n=%0d bits=%b done=%0d exp n=4 bits=1011 done=1", nv, b[3:0], nd);
        end
        // start was still high during DONE; that must not have launched a transfer
        checks++; if (busy !== 1'b0 || dut.state !== IDLE) begin
            errors++; $display("FAIL busy_relaunch: got busy=%b state=%0d exp 0 0", busy, dut.state);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_after: got %b exp 0", busy);
        end
    endtask

    task automatic test_abort();
        int nd;
        start_xfer(8'b1011_0000, 4'd4, 4'd0);
        @(negedge clk);
        @(negedge clk);              // third bit cycle
        checks++; if (valid !== 1'b1 || out !== 1'b1) begin
            errors++; $display("FAIL abort_bit3: got valid=%b out=%b exp 1 1", valid, out);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({out, valid, busy, done} !== 4'b0000 || dut.state !== IDLE) begin
            errors++; $display("FAIL abort_idle: got ovbd=%b state=%0d exp 0000 0",
                               {out, valid, busy, done}, dut.state);
        end
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        checks++; if (nd != 0) begin
            errors++; $display("FAIL abort_nodone: got %0d exp 0", nd);
        end
    endtask

    task automatic test_abort_start_idle();
        @(negedge clk);
        data = 8'hFF; len = 4'd4; rep = 4'd0; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || dut.state !== IDLE) begin
            errors++; $display("FAIL abort_wins: got busy=%b valid=%b exp 0 0", busy, valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] b; int nv, nd, bad; bit to;
        start_xfer(8'hA5, 4'd8, 4'd1);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if ({out, valid, busy, done} !== 4'b0000 || dut.state !== IDLE) begin
            errors++; $display("FAIL rst_async: got ovbd=%b state=%0d exp 0000 0",
                               {out, valid, busy, done}, dut.state);
        end
        @(negedge clk); rst = 1'b1;
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            if (done || busy) nd++;
            @(negedge clk);
        end
        checks++; if (nd != 0) begin
            errors++; $display("FAIL rst_waits_idle: got %0d busy/done cycles exp 0", nd);
        end
        start_xfer(8'hC3, 4'd8, 4'd0);
        collect(30, b, nv, nd, bad, to);
        checks++; if (to || nv != 8 || b[7:0] !== 8'hC3 || nd != 1) begin
            errors++; $display("FAIL rst_restart: got n=%0d bits=%h done=%0d exp n=8 bits=c3 done=1", nv, b[7:0], nd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_len_clamp();
        test_start_busy();
        test_abort();
        test_abort_start_idle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
